// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types for the memory port arbiter: the sequencing FSM state enum and
// the owner encoding that identifies which pipeline stage holds the port.
// Reused by the processor top and by the arbiter bench.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD0 = 2'd1,
    WORD1 = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// req_latch
// Holds the granted request (owner, we, two, addr, wdata) for the duration of
// a transaction so that requester inputs may change freely once granted.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         capture the *_i fields this cycle (grant in IDLE)
//   owner_i..      request fields to capture
//   owner_o..      captured request fields
module req_latch
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  owner_e              owner_i,
  input  logic                we_i,
  input  logic                two_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [2*WORD_W-1:0] wdata_i,
  output owner_e              owner_o,
  output logic                we_o,
  output logic                two_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [2*WORD_W-1:0] wdata_o
);

  owner_e                owner_q;
  logic                  we_q;
  logic                  two_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2*WORD_W-1:0]   wdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      two_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load_i) begin
      owner_q <= owner_i;
      we_q    <= we_i;
      two_q   <= two_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  assign owner_o = owner_q;
  assign we_o    = we_q;
  assign two_o   = two_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-ported word memory between the fetch stage (if_*) and the
// memory stage (dm_*). Serialises one- or two-word accesses onto the memory
// read/write strobes, assembles big-endian 32-bit read data and returns a
// one-cycle done pulse to the owning requester.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_two/if_addr        fetch request (read only)
//   if_done/if_rdata             fetch completion pulse and data
//   dm_req/dm_we/dm_two/...      data request
//   dm_done/dm_rdata             data completion pulse and data
//   mem_rd/mem_raddr             memory read strobe and address
//   mem_wr/mem_waddr/mem_wdata   memory write strobe, address, word
//   mem_rdata                    memory read word (valid after issue negedge)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic                if_two,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [2*WORD_W-1:0] if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic                dm_two,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [2*WORD_W-1:0] dm_wdata,
  output logic                dm_done,
  output logic [2*WORD_W-1:0] dm_rdata,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e           state_q;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 if_done_q, dm_done_q;
  logic [WORD_W-1:0]    if_hi_q, if_lo_q, dm_hi_q, dm_lo_q;

  // Latched request
  owner_e               lat_owner;
  logic                 lat_we, lat_two;
  logic [ADDR_W-1:0]    lat_addr;
  logic [2*WORD_W-1:0]  lat_wdata;

  // Grant selection
  logic                 any_req, fetch_wins, load;
  owner_e               sel_owner;
  logic                 sel_we, sel_two;
  logic [ADDR_W-1:0]    sel_addr;
  logic [2*WORD_W-1:0]  sel_wdata;
  logic [ADDR_W-1:0]    acc_addr;

  // Data normally has priority; a fetch that has waited STARVE_LIMIT cycles
  // takes the port ahead of a pending data request.
  always_comb begin
    any_req    = if_req | dm_req;
    fetch_wins = if_req & (~dm_req | (starve_q == LIMIT_C));
    load       = (state_q == IDLE) & any_req;
    sel_owner  = fetch_wins ? OWN_IF : OWN_DM;
    sel_we     = fetch_wins ? 1'b0 : dm_we;
    sel_two    = fetch_wins ? if_two : dm_two;
    sel_addr   = fetch_wins ? if_addr : dm_addr;
    sel_wdata  = fetch_wins ? '0 : dm_wdata;
  end

  // Count only while the fetch is waiting, i.e. not while it owns the port.
  always_comb begin
    starve_d = starve_q;
    if ((state_q == IDLE) && fetch_wins) begin
      starve_d = '0;
    end else if (if_req && (starve_q != LIMIT_C) &&
                 !((state_q != IDLE) && (lat_owner == OWN_IF))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  req_latch #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_req_latch (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .owner_i (sel_owner),
    .we_i    (sel_we),
    .two_i   (sel_two),
    .addr_i  (sel_addr),
    .wdata_i (sel_wdata),
    .owner_o (lat_owner),
    .we_o    (lat_we),
    .two_o   (lat_two),
    .addr_o  (lat_addr),
    .wdata_o (lat_wdata)
  );

  // Memory strobes decode straight from registered state, so they only move
  // just after posedge. The second word sits at addr+1 (wraps at 2^ADDR_W).
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    acc_addr  = (state_q == WORD1) ? lat_addr + ADDR_W'(1) : lat_addr;
    if ((state_q == WORD0) || (state_q == WORD1)) begin
      if (lat_we) begin
        mem_wr    = 1'b1;
        mem_waddr = acc_addr;
        mem_wdata = ((state_q == WORD0) && lat_two) ? lat_wdata[2*WORD_W-1:WORD_W]
                                                    : lat_wdata[WORD_W-1:0];
      end else begin
        mem_rd    = 1'b1;
        mem_raddr = acc_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      if_hi_q   <= '0;
      if_lo_q   <= '0;
      dm_hi_q   <= '0;
      dm_lo_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) state_q <= WORD0;
        end
        WORD0: begin
          // First word is the high half of a double, or the only (low) word.
          if (!lat_we) begin
            if (lat_two) begin
              if (lat_owner == OWN_IF) if_hi_q <= mem_rdata;
              else                     dm_hi_q <= mem_rdata;
            end else if (lat_owner == OWN_IF) begin
              if_hi_q <= '0;
              if_lo_q <= mem_rdata;
            end else begin
              dm_hi_q <= '0;
              dm_lo_q <= mem_rdata;
            end
          end
          if (lat_two) begin
            state_q <= WORD1;
          end else begin
            state_q   <= RESP;
            if_done_q <= (lat_owner == OWN_IF);
            dm_done_q <= (lat_owner == OWN_DM);
          end
        end
        WORD1: begin
          if (!lat_we) begin
            if (lat_owner == OWN_IF) if_lo_q <= mem_rdata;
            else                     dm_lo_q <= mem_rdata;
          end
          state_q   <= RESP;
          if_done_q <= (lat_owner == OWN_IF);
          dm_done_q <= (lat_owner == OWN_DM);
        end
        RESP: begin
          // No grant here: gives the finished requester a cycle to drop req.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done  = if_done_q;
  assign dm_done  = dm_done_q;
  assign if_rdata = {if_hi_q, if_lo_q};
  assign dm_rdata = {dm_hi_q, dm_lo_q};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_two = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0, dm_two = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_raddr, mem_waddr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .WORD_W       (16),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_two(if_two), .if_addr(if_addr),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_two(dm_two), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory instance: writes on posedge, read data appears on negedge.
  logic [15:0] mem    [logic [31:0]];
  logic [15:0] refmem [logic [31:0]];

  function automatic logic [15:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  function automatic logic [15:0] rd_ref(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : 16'h0;
  endfunction

  always @(posedge clk) if (mem_wr) mem[mem_waddr] = mem_wdata;
  always @(negedge clk) if (mem_rd) mem_rdata = rd_mem(mem_raddr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Directed transaction table
  typedef struct {
    owner_e      own;
    bit          we;
    bit          two;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] a0, a1;
    logic [15:0] w0, w1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    int          lat, ns;
    logic [31:0] sa [2];
    logic [15:0] sw [2];
    logic        sk [2];
    logic [31:0] rd;
    lat = 0; ns = 0;
    for (int k = 0; k < 2; k++) begin sa[k] = '0; sw[k] = '0; sk[k] = 1'b0; end
    if (v.own == OWN_DM) begin
      dm_req = 1'b1; dm_we = v.we; dm_two = v.two; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_two = v.two; if_addr = v.addr;
    end
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (mem_rd || mem_wr) begin
        if (ns < 2) begin
          sa[ns] = mem_wr ? mem_waddr : mem_raddr;
          sw[ns] = mem_wdata;
          sk[ns] = mem_wr;
        end
        ns++;
      end
      if ((v.own == OWN_DM) ? dm_done : if_done) begin
        lat = c;
        break;
      end
    end
    rd = (v.own == OWN_DM) ? dm_rdata : if_rdata;
    if_req = 1'b0; dm_req = 1'b0;
    check($sformatf("vec%0d_latency", idx), lat, v.lat);
    check($sformatf("vec%0d_nstrobes", idx), ns, v.two ? 2 : 1);
    check($sformatf("vec%0d_kind0", idx), sk[0], v.we);
    check($sformatf("vec%0d_addr0", idx), sa[0], v.a0);
    if (v.we) check($sformatf("vec%0d_wdata0", idx), sw[0], v.w0);
    if (v.two) begin
      check($sformatf("vec%0d_kind1", idx), sk[1], v.we);
      check($sformatf("vec%0d_addr1", idx), sa[1], v.a1);
      if (v.we) check($sformatf("vec%0d_wdata1", idx), sw[1], v.w1);
    end
    check($sformatf("vec%0d_rdata", idx), rd, v.rdata);
    tick;
  endtask

  // Reference model: transaction-level view (who holds the port, how many
  // cycles into the transaction, what was fetched from its own memory copy).
  bit          m_busy;
  int          m_t;
  owner_e      m_own;
  bit          m_we, m_two;
  logic [31:0] m_addr, m_wdata;
  int          m_cnt;
  logic [31:0] m_if_rd, m_dm_rd;

  logic        s_rst, s_if, s_dm, s_if_two, s_dm_we, s_dm_two;
  logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata;

  logic        e_rd, e_wr, e_ifd, e_dmd;
  logic [31:0] e_raddr, e_waddr;
  logic [15:0] e_wdata;

  task automatic model_edge;
    bit fg;
    int len;
    if (s_rst) begin
      m_busy = 0; m_cnt = 0; m_if_rd = '0; m_dm_rd = '0;
      return;
    end
    fg = !m_busy && s_if && (!s_dm || m_cnt == LIM);
    if (fg) m_cnt = 0;
    else if (s_if && !(m_busy && m_own == OWN_IF)) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    if (m_busy) begin
      len = m_two ? 3 : 2;
      if (m_t == len) m_busy = 0;
      else begin
        m_t++;
        if (m_t == len && !m_we) begin
          if (m_own == OWN_IF)
            m_if_rd = m_two ? {rd_ref(m_addr), rd_ref(m_addr + 32'd1)} : {16'h0, rd_ref(m_addr)};
          else
            m_dm_rd = m_two ? {rd_ref(m_addr), rd_ref(m_addr + 32'd1)} : {16'h0, rd_ref(m_addr)};
        end
      end
    end else if (s_if || s_dm) begin
      m_busy = 1; m_t = 1;
      if (fg) begin
        m_own = OWN_IF; m_we = 0; m_two = s_if_two; m_addr = s_if_addr; m_wdata = '0;
      end else begin
        m_own = OWN_DM; m_we = s_dm_we; m_two = s_dm_two; m_addr = s_dm_addr; m_wdata = s_dm_wdata;
      end
    end
  endtask

  task automatic model_outputs;
    int          acc;
    logic [31:0] a;
    e_rd = 0; e_wr = 0; e_ifd = 0; e_dmd = 0;
    e_raddr = '0; e_waddr = '0; e_wdata = '0;
    if (m_busy) begin
      acc = m_t - 1;
      if (acc < (m_two ? 2 : 1)) begin
        a = m_addr + 32'(acc);
        if (m_we) begin
          e_wr = 1; e_waddr = a;
          e_wdata = (m_two && acc == 0) ? m_wdata[31:16] : m_wdata[15:0];
          refmem[a] = e_wdata;
        end else begin
          e_rd = 1; e_raddr = a;
        end
      end
      if (m_t == (m_two ? 3 : 2)) begin
        e_ifd = (m_own == OWN_IF);
        e_dmd = (m_own == OWN_DM);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 31));
    return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    int dm_at, if_at, dm_n, if_n, dm_before;

    // Reset state
    rst = 1'b1;
    tick; tick;
    check("reset_ctrl", {if_done, dm_done, mem_rd, mem_wr, mem_raddr, mem_waddr, mem_wdata}, '0);
    check("reset_rdata", {if_rdata, dm_rdata}, '0);
    rst = 1'b0;
    tick;

    mem[32'h20] = 16'h1234;
    mem[32'h21] = 16'h5678;

    //          own     we two addr          wdata         lat a0            a1     w0       w1       rdata
    vecs[0] = '{OWN_DM, 1, 0, 32'h10,       32'h0000_ABCD, 2, 32'h10,       32'h0, 16'hABCD, 16'h0,    32'h0};
    vecs[1] = '{OWN_IF, 0, 1, 32'h20,       32'h0,         3, 32'h20,       32'h21, 16'h0,   16'h0,    32'h1234_5678};
    vecs[2] = '{OWN_DM, 1, 1, 32'hFFFF_FFFF, 32'hAAAA_5555, 3, 32'hFFFF_FFFF, 32'h0, 16'hAAAA, 16'h5555, 32'h0};
    vecs[3] = '{OWN_DM, 0, 1, 32'hFFFF_FFFF, 32'h0,         3, 32'hFFFF_FFFF, 32'h0, 16'h0,   16'h0,    32'hAAAA_5555};
    vecs[4] = '{OWN_IF, 0, 0, 32'h10,       32'h0,         2, 32'h10,       32'h0, 16'h0,    16'h0,    32'h0000_ABCD};
    vecs[5] = '{OWN_DM, 0, 0, 32'h21,       32'h0,         2, 32'h21,       32'h0, 16'h0,    16'h0,    32'h0000_5678};
    vecs[6] = '{OWN_DM, 1, 0, 32'h30,       32'h1111_9999, 2, 32'h30,       32'h0, 16'h9999, 16'h0,    32'h0000_5678};
    vecs[7] = '{OWN_IF, 0, 0, 32'h30,       32'h0,         2, 32'h30,       32'h0, 16'h0,    16'h0,    32'h0000_9999};
    vecs[8] = '{OWN_IF, 0, 1, 32'h20,       32'h0,         3, 32'h20,       32'h21, 16'h0,   16'h0,    32'h1234_5678};

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    check("wrap_mem_hi", rd_mem(32'hFFFF_FFFF), 16'hAAAA);
    check("wrap_mem_lo", rd_mem(32'h0), 16'h5555);

    // Contention: both raised together, data first, fetch in the next IDLE
    dm_at = 0; if_at = 0; dm_n = 0; if_n = 0;
    if_req = 1; if_two = 0; if_addr = 32'h20;
    dm_req = 1; dm_we = 0; dm_two = 0; dm_addr = 32'h21;
    for (int c = 1; c <= 15; c++) begin
      tick;
      if (dm_done) begin dm_n++; dm_at = c; dm_req = 0; check("cont_dm_rdata", dm_rdata, 32'h0000_5678); end
      if (if_done) begin if_n++; if_at = c; if_req = 0; check("cont_if_rdata", if_rdata, 32'h0000_1234); end
    end
    check("cont_dm_cycle", dm_at, 2);
    check("cont_if_cycle", if_at, 5);
    check("cont_dm_pulses", dm_n, 1);
    check("cont_if_pulses", if_n, 1);

    // Starvation: data re-raised continuously; fetch wins after the count saturates
    if_at = 0; dm_before = 0;
    if_req = 1; if_two = 0; if_addr = 32'h10;
    dm_req = 1; dm_we = 0; dm_two = 0; dm_addr = 32'h21;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (if_done) begin if_at = c; if_req = 0; check("starve_if_rdata", if_rdata, 32'h0000_ABCD); end
      if (dm_done) begin
        dm_req = 0;
        if (if_at == 0) dm_before++;
      end else if (!dm_req && if_at == 0) dm_req = 1;
    end
    check("starve_if_cycle", if_at, 8);
    check("starve_dm_before", dm_before, 2);

    // Reset during WORD1 of a double read
    if_req = 1; if_two = 1; if_addr = 32'h20;
    tick;
    check("rst_seq_word0", {mem_rd, mem_raddr}, {1'b1, 32'h20});
    tick;
    check("rst_seq_word1", {mem_rd, mem_raddr}, {1'b1, 32'h21});
    rst = 1;
    tick;
    check("rst_seq_ctrl", {if_done, dm_done, mem_rd, mem_wr, mem_raddr, mem_waddr, mem_wdata}, '0);
    check("rst_seq_rdata", {if_rdata, dm_rdata}, '0);
    rst = 0; if_req = 0;
    tick;
    check("rst_seq_no_done", {if_done, dm_done, mem_rd, mem_wr}, '0);
    run_vec(8, vecs[8]);

    // Randomized traffic against the reference model
    refmem = mem;
    m_busy = 0; m_t = 0; m_own = OWN_IF; m_we = 0; m_two = 0;
    m_addr = '0; m_wdata = '0; m_cnt = 0; m_if_rd = '0; m_dm_rd = '0;
    rst = 1;
    for (int c = 0; c < 600; c++) begin
      s_rst = rst; s_if = if_req; s_dm = dm_req;
      s_if_two = if_two; s_if_addr = if_addr;
      s_dm_we = dm_we; s_dm_two = dm_two; s_dm_addr = dm_addr; s_dm_wdata = dm_wdata;
      tick;
      model_edge();
      model_outputs();
      check($sformatf("rand%0d_outputs", c),
            {e_rd, e_wr, e_ifd, e_dmd, e_raddr, e_waddr, e_wdata},
            {mem_rd, mem_wr, if_done, dm_done, mem_raddr, mem_waddr, mem_wdata});
      if (!m_busy || m_t == (m_two ? 3 : 2))
        check($sformatf("rand%0d_rdata", c), {if_rdata, dm_rdata}, {m_if_rd, m_dm_rd});
      if (s_rst) begin
        if_req = 0; dm_req = 0;
      end else begin
        if (if_req && if_done) if_req = 0;
        else if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1; if_two = 1'($urandom_range(0, 1)); if_addr = rand_addr();
        end
        if (dm_req && dm_done) dm_req = 0;
        else if (!dm_req && $urandom_range(0, 2) != 0) begin
          dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_two = 1'($urandom_range(0, 1));
          dm_addr = rand_addr(); dm_wdata = $urandom;
        end
      end
      rst = ($urandom_range(0, 59) == 0);
    end
    rst = 0; if_req = 0; dm_req = 0;
    tick; tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported 16-bit word memory between the fetch stage and the memory stage. Each requester issues a one- or two-word access; the arbiter serialises the accesses onto the memory's read and write ports, sequences two-word (32-bit) transfers, and returns assembled read data with a one-cycle done pulse. It sits between the pipeline front/back ends and the memory instance. It owns all `memR`/`memWR` strobes.

## Interface

Parameters:
- ADDR_W, 32, address width; must match the memory's address bus width.
- WORD_W, 16, memory word width.
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may be blocked by data before it wins priority.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- if_req  in  1  fetch request; held high until if_done.
- if_two  in  1  fetch needs two words; sampled with if_req.
- if_addr  in  ADDR_W  fetch word address.
- if_done  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  2*WORD_W  fetched data.
- dm_req  in  1  data request; held high until dm_done.
- dm_we  in  1  1 = write, 0 = read.
- dm_two  in  1  two-word access.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  2*WORD_W  write data.
- dm_done  out  1  one-cycle pulse.
- dm_rdata  out  2*WORD_W  read data.
- mem_rd  out  1  memory read strobe (memR).
- mem_wr  out  1  memory write strobe (memWR).
- mem_raddr  out  ADDR_W  read address.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  WORD_W  write word.
- mem_rdata  in  WORD_W  memory read data; updated on the negedge of the issue cycle.

## Operation

- The FSM has four states: IDLE, WORD0, WORD1, RESP.
- **IDLE**
  - If a request is pending, latch it (owner, we, two, addr, wdata) and go to WORD0.
  - Priority: data over fetch, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - If no request is pending, stay in IDLE.
- **WORD0**
  - Drive a single access at addr:
    - read: mem_rd = 1, mem_raddr = addr;
    - write: mem_wr = 1, mem_waddr = addr, mem_wdata = wdata[31:16] if two, else wdata[15:0].
  - Read: on the posedge ending WORD0, capture mem_rdata into hi if two, else into lo.
  - Next state: WORD1 if two, else RESP.
- **WORD1**
  - Access addr+1, computed modulo 2^ADDR_W (so 0xFFFFFFFF wraps to 0).
  - Write data is wdata[15:0]; read data is captured into lo.
  - Next state: RESP.
- **RESP**
  - Assert the owner's done for exactly one cycle.
  - rdata = {hi, lo}; for a single-word access, hi = 0.
  - No memory strobe is driven, and no new grant is made. This guarantees the requester deasserts req before it can be re-sampled.
  - Next state: IDLE.
- Word order is big-endian: the high half is at addr and the low half at addr+1.
- rdata registers hold their value until the next capture. Writes leave rdata unchanged.
- starve_cnt:
  - increments, saturating at STARVE_LIMIT, on each cycle that if_req is high and the fetch is not the owner;
  - clears when a fetch is granted.
- Request inputs are ignored outside IDLE. A requester changing addr or wdata mid-transaction has no effect.

## Timing

- Memory strobes and addresses are combinational from the state and latched-request registers. They are glitch-free relative to posedge, because the memory writes on posedge and reads on negedge.
- Latency from grant (IDLE sees req) to done:
  - single word: 2 cycles (WORD0, RESP);
  - two words: 3 cycles (WORD0, WORD1, RESP).
- Maximum throughput is one transaction every 3 cycles (single word) or 4 cycles (double word), counting the IDLE grant cycle.
- Reset values:
  - state = IDLE, starve_cnt = 0;
  - if_done, dm_done, mem_rd, mem_wr = 0;
  - if_rdata, dm_rdata, mem_raddr, mem_waddr, mem_wdata = 0.
- rst asserted mid-transaction: return to IDLE on the next posedge with no done pulse and no further strobes. A partially written double word is left as is.
- Simultaneous if_req and dm_req in IDLE: data is granted; fetch waits and starve_cnt counts.

## Structure

- Shared package holds the FSM state enum (IDLE, WORD0, WORD1, RESP) and the owner encoding (OWN_IF, OWN_DM). The processor top and the bench reuse both.
- One natural sub-module, `req_latch`, holding the captured owner/we/two/addr/wdata. The rest is a single FSM module.

## Test plan

- **Single data write:** dm_req, we = 1, two = 0, addr = 0x10, wdata = 0x0000_ABCD.
  - mem_wr high for exactly 1 cycle with waddr = 0x10, wdata = 0xABCD.
  - dm_done 2 cycles after grant.
- **Double read:** preload 0x20 = 0x1234, 0x21 = 0x5678; fetch two = 1, addr = 0x20.
  - Two mem_rd cycles at 0x20 and 0x21.
  - if_rdata = 0x1234_5678 with if_done 3 cycles after grant.
- **Contention:** if_req and dm_req raised in the same cycle.
  - Data is served first; fetch is served in the next IDLE.
  - Exactly one done pulse per requester.
- **Starvation:** if_req held while dm_req is re-raised continuously.
  - Once starve_cnt reaches 4, fetch is granted ahead of a pending data request.
- **Address wrap:** double write at addr = 0xFFFF_FFFF, wdata = 0xAAAA_5555.
  - Writes 0xAAAA at 0xFFFF_FFFF and 0x5555 at 0x0.
- **Reset mid-transaction:** rst asserted during WORD1 of a double read.
  - No done pulse, state back to IDLE, all outputs 0 on the next cycle.
  - A new request then completes normally.
